// File: rtl/exibe_sequencia_if.sv
// rtl/exibe_sequencia_if.sv - game-FSM handshake and ROM address path of the sequence display
interface exibe_sequencia_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              iniciar;
    logic [ADDR_W-1:0] limite;
    logic              ocupado;
    logic              pronto;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    modport master (
        output iniciar, limite, rom_data,
        input  ocupado, pronto, rom_addr
    );

    modport slave (
        input  iniciar, limite, rom_data,
        output ocupado, pronto, rom_addr
    );
endinterface

// File: rtl/exibe_sequencia.sv
// rtl/exibe_sequencia.sv - shows ROM entries 0..limite on the LEDs (TON on, TOFF off each)
// Optional EXIBE_PAUSA_EN adds a 'pausa' input that freezes the display while lit or blanked.
module exibe_sequencia #(
    parameter int TON    = 500,
    parameter int TOFF   = 250,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
`ifdef EXIBE_PAUSA_EN
    input  logic              pausa,
`endif
    exibe_sequencia_if.slave  bus,
    output logic [DATA_W-1:0] leds,
    output logic [3:0]        db_estado
);

    localparam int TMAX = (TON > TOFF) ? TON : TOFF;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TON_LAST  = TW'(TON - 1);
    localparam logic [TW-1:0] TOFF_LAST = TW'(TOFF - 1);

    typedef enum logic [3:0] {
        OCIOSO   = 4'h0,
        ENDERECA = 4'h1,
        CARREGA  = 4'h2,
        ACENDE   = 4'h3,
        APAGA    = 4'h4,
        FIM      = 4'hF
    } estado_t;

    estado_t           estado, estado_n;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_n;
    logic [ADDR_W-1:0] limite_q, limite_n;
    logic [DATA_W-1:0] leds_n;
    logic [TW-1:0]     timer, timer_n;
    logic              congela;

`ifdef EXIBE_PAUSA_EN
    assign congela = pausa;
`else
    assign congela = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado     <= OCIOSO;
            rom_addr_q <= '0;
            limite_q   <= '0;
            leds       <= '0;
            timer      <= '0;
        end else begin
            estado     <= estado_n;
            rom_addr_q <= rom_addr_n;
            limite_q   <= limite_n;
            leds       <= leds_n;
            timer      <= timer_n;
        end
    end

    always_comb begin
        estado_n   = estado;
        rom_addr_n = rom_addr_q;
        limite_n   = limite_q;
        leds_n     = leds;
        timer_n    = timer;
        case (estado)
            OCIOSO: begin
                if (bus.iniciar) begin
                    limite_n   = bus.limite;
                    rom_addr_n = '0;
                    estado_n   = ENDERECA;
                end
            end
            ENDERECA: estado_n = CARREGA;
            CARREGA: begin
                // sync ROM output is valid now for the address set in ENDERECA
                leds_n   = bus.rom_data;
                timer_n  = '0;
                estado_n = ACENDE;
            end
            ACENDE: begin
                if (!congela) begin
                    if (timer == TON_LAST) begin
                        leds_n   = '0;
                        timer_n  = '0;
                        estado_n = APAGA;
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
            end
            APAGA: begin
                if (!congela) begin
                    if (timer == TOFF_LAST) begin
                        timer_n = '0;
                        if (rom_addr_q == limite_q) begin
                            estado_n = FIM;
                        end else begin
                            rom_addr_n = rom_addr_q + 1'b1;
                            estado_n   = ENDERECA;
                        end
                    end else begin
                        timer_n = timer + 1'b1;
                    end
                end
            end
            FIM: begin
                rom_addr_n = '0;
                estado_n   = OCIOSO;
            end
            default: estado_n = OCIOSO;
        endcase
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.ocupado  = (estado != OCIOSO);
    assign bus.pronto   = (estado == FIM);
    assign db_estado    = estado;

endmodule
